// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Sequences single-word load/store requests from a datapath onto a simple
// strobed memory port. A request is taken only while idle. Its address is
// range-checked against ADDR_LIMIT. A valid request holds the matching
// strobe for WAIT_CYCLES cycles, then gives a one-cycle done pulse. An
// out-of-range request gives a one-cycle done plus addr_error pulse and
// never touches memory.
//
// Parameters
//   ADDR_LIMIT   number of valid word addresses (0..ADDR_LIMIT-1)
//   WAIT_CYCLES  cycles the memory strobe is held per access (1..15)
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   req             access request, sampled only while idle
//   req_write       1 = store, 0 = load
//   req_address     word address of the request
//   req_data        signed store data
//   busy            high whenever the unit is not idle
//   done            one-cycle completion pulse
//   addr_error      one-cycle pulse for an out-of-range request
//   load_data       last loaded word, held until the next load completes
//   mem_address     registered address to memory
//   mem_write_data  registered store data to memory
//   mem_r_flag      memory read strobe
//   mem_w_flag      memory write strobe
//   mem_read_data   read data from memory, valid while mem_r_flag is high
module mem_access_unit #(
    parameter int ADDR_LIMIT  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               req_write,
    input  logic        [15:0] req_address,
    input  logic signed [15:0] req_data,
    output logic               busy,
    output logic               done,
    output logic               addr_error,
    output logic signed [15:0] load_data,
    output logic        [15:0] mem_address,
    output logic signed [15:0] mem_write_data,
    output logic               mem_r_flag,
    output logic               mem_w_flag,
    input  logic signed [15:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERROR
    } state_t;

    // One extra bit keeps the unsigned compare correct for ADDR_LIMIT = 65536.
    localparam logic [16:0] ADDR_BOUND = 17'(ADDR_LIMIT);
    // The counter counts down to zero. So loading WAIT_CYCLES-1 gives exactly
    // WAIT_CYCLES access cycles, and the counter never has to wrap.
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_count;
    logic        op_write;
    logic        accept;
    logic        last_access;

    // State register. Reset is asynchronous, so every state-decoded output
    // drops to zero as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. All outputs are pure functions of the
    // state and the latched op bit, so the two strobes cannot overlap and the
    // done and addr_error pulses last exactly one cycle.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        last_access = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        addr_error  = 1'b0;
        mem_r_flag  = 1'b0;
        mem_w_flag  = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if ({1'b0, req_address} < ADDR_BOUND) begin
                        accept     = 1'b1;
                        next_state = S_ACCESS;
                    end else begin
                        next_state = S_ERROR;
                    end
                end
            end
            S_ACCESS: begin
                mem_r_flag = ~op_write;
                mem_w_flag = op_write;
                if (wait_count == 4'd0) begin
                    last_access = 1'b1;
                    next_state  = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            S_ERROR: begin
                done       = 1'b1;
                addr_error = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request latches, wait counter and load capture. A rejected request
    // leaves the address, data and op bit untouched. load_data changes only
    // at the final edge of a load access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count     <= 4'd0;
            op_write       <= 1'b0;
            mem_address    <= 16'd0;
            mem_write_data <= 16'sd0;
            load_data      <= 16'sd0;
        end else begin
            if (accept) begin
                mem_address    <= req_address;
                mem_write_data <= req_data;
                op_write       <= req_write;
                wait_count     <= WAIT_LOAD;
            end else if (state == S_ACCESS && wait_count != 4'd0) begin
                wait_count <= wait_count - 4'd1;
            end
            if (last_access && !op_write) begin
                load_data <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// ------------------
// Directed bench for mem_access_unit. The instance u_dut0 uses the default
// parameters (WAIT_CYCLES=1). The instance u_dut3 uses WAIT_CYCLES=3. Both
// instances share the clock and reset. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, so nothing races the active
// rising edge. Each task's comments label the cycles relative to the
// accepting edge E.
module tb_mem_access_unit;

    logic               clk;
    logic               reset;

    logic               req;
    logic               req_write;
    logic        [15:0] req_address;
    logic signed [15:0] req_data;
    logic               busy;
    logic               done;
    logic               addr_error;
    logic signed [15:0] load_data;
    logic        [15:0] mem_address;
    logic signed [15:0] mem_write_data;
    logic               mem_r_flag;
    logic               mem_w_flag;
    logic signed [15:0] mem_read_data;

    logic               req3;
    logic               req_write3;
    logic        [15:0] req_address3;
    logic signed [15:0] req_data3;
    logic               busy3;
    logic               done3;
    logic               addr_error3;
    logic signed [15:0] load_data3;
    logic        [15:0] mem_address3;
    logic signed [15:0] mem_write_data3;
    logic               mem_r_flag3;
    logic               mem_w_flag3;
    logic signed [15:0] mem_read_data3;

    int total = 0;
    int bad   = 0;

    mem_access_unit u_dut0 (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .busy(busy), .done(done),
        .addr_error(addr_error), .load_data(load_data), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_r_flag(mem_r_flag),
        .mem_w_flag(mem_w_flag), .mem_read_data(mem_read_data)
    );

    mem_access_unit #(.ADDR_LIMIT(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_write(req_write3),
        .req_address(req_address3), .req_data(req_data3), .busy(busy3), .done(done3),
        .addr_error(addr_error3), .load_data(load_data3), .mem_address(mem_address3),
        .mem_write_data(mem_write_data3), .mem_r_flag(mem_r_flag3),
        .mem_w_flag(mem_w_flag3), .mem_read_data(mem_read_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset is applied before the first rising edge. Every output must
    // already be zero at that point, because the reset is asynchronous.
    task automatic test_reset();
        #2;
        total++; if ({busy, done, addr_error, mem_r_flag, mem_w_flag} !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00000", {busy, done, addr_error, mem_r_flag, mem_w_flag}); end
        total++; if ({load_data, mem_address, mem_write_data} !== 48'h0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", {load_data, mem_address, mem_write_data}); end
        total++; if ({busy3, done3, addr_error3, mem_r_flag3, mem_w_flag3} !== 5'b0) begin bad++; $display("[TB] FAIL reset3_flags got=%b want=00000", {busy3, done3, addr_error3, mem_r_flag3, mem_w_flag3}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Load from address 3 with memory returning 0x1234.
    task automatic test_load();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_address = 16'd3; req_data = 16'sh0000;
        mem_read_data = 16'sh1234;
        @(negedge clk); req = 1'b0;                                // E+1
        total++; if (mem_r_flag !== 1'b1 || mem_w_flag !== 1'b0) begin bad++; $display("[TB] FAIL load_strobe got r=%b w=%b want r=1 w=0", mem_r_flag, mem_w_flag); end
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL load_busy got busy=%b done=%b want 1 0", busy, done); end
        total++; if (mem_address !== 16'd3) begin bad++; $display("[TB] FAIL load_addr got=%0d want=3", mem_address); end
        total++; if (load_data !== 16'sh0000) begin bad++; $display("[TB] FAIL load_early got=%h want=0000", load_data); end
        @(negedge clk);                                            // E+2
        total++; if (done !== 1'b1 || addr_error !== 1'b0 || mem_r_flag !== 1'b0) begin bad++; $display("[TB] FAIL load_done got done=%b err=%b r=%b want 1 0 0", done, addr_error, mem_r_flag); end
        total++; if (load_data !== 16'sh1234) begin bad++; $display("[TB] FAIL load_data got=%h want=1234", load_data); end
        @(negedge clk);                                            // E+3
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL load_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    // Store of 0x1234 to address 3. The memory bus carries junk read data,
    // and load_data must keep its value.
    task automatic test_store();
        @(negedge clk);
        req = 1'b1; req_write = 1'b1; req_address = 16'd3; req_data = 16'sh1234;
        mem_read_data = 16'shDEAD;
        @(negedge clk); req = 1'b0;                                // E+1
        total++; if (mem_w_flag !== 1'b1 || mem_r_flag !== 1'b0) begin bad++; $display("[TB] FAIL store_strobe got w=%b r=%b want w=1 r=0", mem_w_flag, mem_r_flag); end
        total++; if (mem_address !== 16'd3 || mem_write_data !== 16'sh1234) begin bad++; $display("[TB] FAIL store_bus got addr=%0d data=%h want 3 1234", mem_address, mem_write_data); end
        @(negedge clk);                                            // E+2
        total++; if (done !== 1'b1 || mem_w_flag !== 1'b0) begin bad++; $display("[TB] FAIL store_done got done=%b w=%b want 1 0", done, mem_w_flag); end
        total++; if (load_data !== 16'sh1234) begin bad++; $display("[TB] FAIL store_hold got=%h want=1234", load_data); end
        @(negedge clk);                                            // E+3
        total++; if (busy !== 1'b0 || load_data !== 16'sh1234) begin bad++; $display("[TB] FAIL store_idle got busy=%b ld=%h want 0 1234", busy, load_data); end
    endtask

    // Address 15 is the highest valid address, so this load must be accepted.
    task automatic test_boundary();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_address = 16'd15; req_data = 16'sh0000;
        mem_read_data = 16'sh0F0F;
        @(negedge clk); req = 1'b0;                                // E+1
        total++; if (mem_r_flag !== 1'b1 || addr_error !== 1'b0 || mem_address !== 16'd15) begin bad++; $display("[TB] FAIL bound_access got r=%b err=%b addr=%0d want 1 0 15", mem_r_flag, addr_error, mem_address); end
        @(negedge clk);                                            // E+2
        total++; if (done !== 1'b1 || load_data !== 16'sh0F0F) begin bad++; $display("[TB] FAIL bound_done got done=%b ld=%h want 1 0f0f", done, load_data); end
        @(negedge clk);
    endtask

    // Address 16 is out of range. The address, data and op bit must stay as
    // they were: addr 15 and data 0 from the boundary load.
    task automatic test_addr_error();
        @(negedge clk);
        req = 1'b1; req_write = 1'b1; req_address = 16'd16; req_data = 16'sh5A5A;
        @(negedge clk); req = 1'b0;                                // E+1
        total++; if (addr_error !== 1'b1 || done !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL err_pulse got err=%b done=%b busy=%b want 1 1 1", addr_error, done, busy); end
        total++; if (mem_r_flag !== 1'b0 || mem_w_flag !== 1'b0) begin bad++; $display("[TB] FAIL err_strobe got r=%b w=%b want 0 0", mem_r_flag, mem_w_flag); end
        total++; if (mem_address !== 16'd15 || mem_write_data !== 16'sh0000) begin bad++; $display("[TB] FAIL err_keep got addr=%0d data=%h want 15 0000", mem_address, mem_write_data); end
        @(negedge clk);                                            // E+2
        total++; if ({addr_error, done, busy, mem_r_flag, mem_w_flag} !== 5'b0) begin bad++; $display("[TB] FAIL err_after got=%b want=00000", {addr_error, done, busy, mem_r_flag, mem_w_flag}); end
    endtask

    // With req held high, a new request is accepted in the first idle cycle.
    // The first part is a valid store. The second part uses 0xFFFF, which is
    // out of range as an unsigned address.
    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; req_write = 1'b1; req_address = 16'd1; req_data = 16'sh1111;
        @(negedge clk);                                            // E+1
        req_address = 16'd2; req_data = 16'sh2222;
        total++; if (mem_w_flag !== 1'b1 || mem_address !== 16'd1) begin bad++; $display("[TB] FAIL b2b_first got w=%b addr=%0d want 1 1", mem_w_flag, mem_address); end
        @(negedge clk);                                            // E+2
        total++; if (done !== 1'b1 || mem_address !== 16'd1) begin bad++; $display("[TB] FAIL b2b_done got done=%b addr=%0d want 1 1", done, mem_address); end
        @(negedge clk);                                            // E+3
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got busy=%b want 0", busy); end
        @(negedge clk); req = 1'b0;                                // E+4
        total++; if (mem_w_flag !== 1'b1 || mem_address !== 16'd2 || mem_write_data !== 16'sh2222) begin bad++; $display("[TB] FAIL b2b_second got w=%b addr=%0d data=%h want 1 2 2222", mem_w_flag, mem_address, mem_write_data); end
        @(negedge clk);                                            // E+5
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done2 got done=%b want 1", done); end
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_address = 16'hFFFF;
        @(negedge clk);                                            // E+1
        total++; if (addr_error !== 1'b1) begin bad++; $display("[TB] FAIL b2b_err1 got err=%b want 1", addr_error); end
        @(negedge clk);                                            // E+2
        total++; if (busy !== 1'b0 || addr_error !== 1'b0) begin bad++; $display("[TB] FAIL b2b_errgap got busy=%b err=%b want 0 0", busy, addr_error); end
        @(negedge clk); req = 1'b0;                                // E+3
        total++; if (addr_error !== 1'b1 || mem_address !== 16'd2) begin bad++; $display("[TB] FAIL b2b_err2 got err=%b addr=%0d want 1 2", addr_error, mem_address); end
        @(negedge clk);
    endtask

    // WAIT_CYCLES=3 load of the negative word 0x8001. Extra requests arrive
    // during the busy cycles and must be ignored.
    task automatic test_wait3_load();
        @(negedge clk);
        req3 = 1'b1; req_write3 = 1'b0; req_address3 = 16'd7; req_data3 = 16'sh0000;
        mem_read_data3 = 16'sh8001;
        @(negedge clk); req_address3 = 16'd20;                     // E+1
        total++; if (mem_r_flag3 !== 1'b1 || mem_w_flag3 !== 1'b0 || busy3 !== 1'b1) begin bad++; $display("[TB] FAIL w3_cyc1 got r=%b w=%b busy=%b want 1 0 1", mem_r_flag3, mem_w_flag3, busy3); end
        @(negedge clk); req_address3 = 16'd2; req_write3 = 1'b1;   // E+2
        total++; if (mem_r_flag3 !== 1'b1 || mem_address3 !== 16'd7 || done3 !== 1'b0) begin bad++; $display("[TB] FAIL w3_cyc2 got r=%b addr=%0d done=%b want 1 7 0", mem_r_flag3, mem_address3, done3); end
        @(negedge clk); req3 = 1'b0;                               // E+3
        total++; if (mem_r_flag3 !== 1'b1 || done3 !== 1'b0 || load_data3 !== 16'sh0000) begin bad++; $display("[TB] FAIL w3_cyc3 got r=%b done=%b ld=%h want 1 0 0000", mem_r_flag3, done3, load_data3); end
        @(negedge clk);                                            // E+4
        total++; if (done3 !== 1'b1 || addr_error3 !== 1'b0 || mem_r_flag3 !== 1'b0) begin bad++; $display("[TB] FAIL w3_done got done=%b err=%b r=%b want 1 0 0", done3, addr_error3, mem_r_flag3); end
        total++; if (load_data3 !== 16'sh8001 || load_data3 >= 0) begin bad++; $display("[TB] FAIL w3_data got=%h want=8001", load_data3); end
        @(negedge clk);                                            // E+5
        total++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("[TB] FAIL w3_idle got busy=%b done=%b want 0 0", busy3, done3); end
        @(negedge clk);                                            // E+6
        total++; if (busy3 !== 1'b0 || mem_address3 !== 16'd7) begin bad++; $display("[TB] FAIL w3_noqueue got busy=%b addr=%0d want 0 7", busy3, mem_address3); end
    endtask

    // Reset arrives in the 2nd cycle of a WAIT_CYCLES=3 access, while clk is
    // low. Every output of both instances must clear before the next rising
    // edge. No done may follow, and a fresh store must then complete.
    task automatic test_reset_abort();
        @(negedge clk);
        req3 = 1'b1; req_write3 = 1'b0; req_address3 = 16'd4; mem_read_data3 = 16'sh4444;
        @(negedge clk); req3 = 1'b0;                               // E+1
        total++; if (mem_r_flag3 !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre got r=%b want 1", mem_r_flag3); end
        @(negedge clk);                                            // E+2
        #2 reset = 1'b1;
        #1;
        total++; if ({busy3, done3, addr_error3, mem_r_flag3, mem_w_flag3} !== 5'b0) begin bad++; $display("[TB] FAIL abort_flags got=%b want=00000", {busy3, done3, addr_error3, mem_r_flag3, mem_w_flag3}); end
        total++; if ({load_data3, mem_address3, mem_write_data3} !== 48'h0) begin bad++; $display("[TB] FAIL abort_data got=%h want=0", {load_data3, mem_address3, mem_write_data3}); end
        total++; if ({load_data, mem_address, mem_write_data} !== 48'h0) begin bad++; $display("[TB] FAIL abort_dut0 got=%h want=0", {load_data, mem_address, mem_write_data}); end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("[TB] FAIL abort_nodone%0d got busy=%b done=%b want 0 0", i, busy3, done3); end
        end
        req3 = 1'b1; req_write3 = 1'b1; req_address3 = 16'd9; req_data3 = 16'sh00AA;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); req3 = 1'b0;                           // E+i
            total++; if (mem_w_flag3 !== 1'b1 || mem_r_flag3 !== 1'b0) begin bad++; $display("[TB] FAIL recover_w%0d got w=%b r=%b want 1 0", i, mem_w_flag3, mem_r_flag3); end
        end
        @(negedge clk);                                            // E+4
        total++; if (done3 !== 1'b1 || mem_write_data3 !== 16'sh00AA || mem_address3 !== 16'd9) begin bad++; $display("[TB] FAIL recover_done got done=%b data=%h addr=%0d want 1 00aa 9", done3, mem_write_data3, mem_address3); end
        @(negedge clk);                                            // E+5
        total++; if (busy3 !== 1'b0) begin bad++; $display("[TB] FAIL recover_idle got busy=%b want 0", busy3); end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        reset = 1'b1;
        req = 1'b0; req_write = 1'b0; req_address = 16'd0; req_data = 16'sh0000;
        mem_read_data = 16'sh0000;
        req3 = 1'b0; req_write3 = 1'b0; req_address3 = 16'd0; req_data3 = 16'sh0000;
        mem_read_data3 = 16'sh0000;
        test_reset();
        test_load();
        test_store();
        test_boundary();
        test_addr_error();
        test_back_to_back();
        test_wait3_load();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
